cook_sequencer: RTL and testbench
=================================

// Module: cook_sequencer
// PURPOSE
//  Front-panel controller for the microwave: turns keypad digits into counter load
//  pulses, then gates the minutes/seconds counter and the magnetron. It enforces the
//  start/stop/clear/door interlock and the power-level duty cycle, and rings the end beep.
//  It sits between the keypad/button synchronisers and minutes_seconds_counter, and
//  replaces the combinational start/stop glue.
// PARAMETERS
//  MAX_DIGITS   4   time digits accepted per entry (M, S10, S1 fit in 3; 4th reserved)
//  DUTY_WINDOW  10  power-level window length in tick_1hz periods
//  BEEP_TICKS   3   tick_1hz periods the beep stays on after cook completion
// PORTS
//  clock          in   1  system clock, all state updates on posedge
//  reset          in   1  asynchronous, active-high; forces IDLE
//  key_valid      in   1  one-cycle pulse: key_code holds a new digit
//  key_code       in   4  digit 0-9; values 10-15 ignored
//  power_key      in   1  one-cycle pulse: next digit selects power level
//  start_pulse    in   1  one-cycle pulse, synchronised start button
//  stop_pulse     in   1  one-cycle pulse, synchronised stop button
//  clear_pulse    in   1  one-cycle pulse, synchronised clear button
//  door_closed    in   1  level, 1 = door latched shut
//  tick_1hz       in   1  one-cycle pulse per second
//  timer_zero     in   1  counter reads 0:00
//  digit_data     out  4  digit presented to counter (valid with digit_load)
//  digit_load     out  1  one-cycle pulse: counter shifts in digit_data
//  counter_clear  out  1  one-cycle pulse: counter clears to 0:00
//  count_enable   out  1  counter may decrement on tick_1hz
//  mag_on         out  1  magnetron drive
//  beep           out  1  completion tone enable
//  state_o        out  3  IDLE=0 ENTRY=1 COOK=2 PAUSED=3 DONE=4
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. power=10, phase=0, digit_cnt=0, power_armed=0.
//  Outputs registered, 1-cycle latency from the causing input. Exception: mag_on is
//    ANDed combinationally with door_closed, so it drops in the same cycle the door opens.
//  Event priority in one cycle: reset > clear > stop > door open > timer_zero > start > digit.
//  power_key (IDLE/ENTRY only): sets power_armed. The next valid digit sets power to that
//    digit (0 -> 10), clears power_armed, and is NOT loaded into the counter.
//  IDLE
//    valid digit -> digit_load pulse, digit_cnt=1, go to ENTRY.
//    start or stop -> ignored.
//    clear -> counter_clear pulse; power returns to 10.
//  ENTRY
//    valid digit with digit_cnt<MAX_DIGITS -> digit_load pulse, digit_cnt++.
//    valid digit at MAX_DIGITS -> silently dropped.
//    start & door_closed & !timer_zero -> COOK, phase=0. Start with door open -> stay.
//    clear or stop -> counter_clear pulse, digit_cnt=0, power=10, go to IDLE.
//  COOK
//    count_enable=1. Each tick_1hz: phase = (phase==DUTY_WINDOW-1) ? 0 : phase+1.
//    mag_on = door_closed & (phase < power). power=10 gives continuous on.
//    Digits and power_key are ignored.
//    stop or !door_closed -> PAUSED; count_enable=0 next cycle; phase held.
//    timer_zero -> DONE.
//  PAUSED
//    count_enable=0, mag_on=0.
//    start & door_closed -> COOK; phase resumes from its held value.
//    stop or clear -> counter_clear pulse, digit_cnt=0, power=10, go to IDLE.
//  DONE
//    mag_on=0, count_enable=0, beep=1.
//    After BEEP_TICKS tick_1hz pulses -> IDLE with beep=0.
//    Any start/stop/clear/valid digit silences beep and goes to IDLE (input consumed).
//  Widths: digit_cnt 3 bits, phase 4 bits, power 4 bits, beep counter 2 bits (sized by params).
//  Reset mid-cook: outputs fall asynchronously, including mag_on. Counter contents are
//    the counter's own concern; no clear pulse is issued on reset.
// TESTING
//  Reset, keys 1,3,0, start, door closed -> three digit_load pulses (data 1,3,0),
//    state_o=2, count_enable=1 and mag_on=1 one cycle after start.
//  Power 5, 12 ticks -> mag_on high for ticks 0-4, low for 5-9, high again from tick 10.
//  Door opens mid-cook -> mag_on=0 in the same cycle, state_o=3 next cycle.
//    Door closed + start -> COOK with phase preserved.
//  Five digits entered -> exactly 4 digit_load pulses. Start with door open -> state stays 1.
//  timer_zero in COOK -> state_o=4, beep=1 for 3 ticks, then state_o=0.
//    Repeat with stop during beep -> IDLE next cycle.
//  Clear and start in the same cycle in ENTRY -> counter_clear pulse, state_o=0, mag_on never set.

Source files
------------

// File: rtl/cook_sequencer.sv
// cook_sequencer
//   Microwave front-panel controller. Turns keypad digits into load pulses for
//   the minutes/seconds counter, gates the counter and the magnetron, enforces
//   the start/stop/clear/door interlock, applies the power-level duty cycle and
//   rings the completion beep.
//
//   Ports
//     clock, reset        system clock; asynchronous active-high reset
//     key_valid/key_code  keypad digit pulse (codes 10-15 ignored)
//     power_key           next digit selects the power level instead of time
//     start/stop/clear    synchronised one-cycle button pulses
//     door_closed         door latch level
//     tick_1hz            one-cycle pulse per second
//     timer_zero          counter reads 0:00
//     digit_data/load     digit shifted into the counter
//     counter_clear       clear the counter to 0:00
//     count_enable        counter may decrement
//     mag_on              magnetron drive (drops combinationally with the door)
//     beep                completion tone
//     state_o             FSM state: IDLE=0 ENTRY=1 COOK=2 PAUSED=3 DONE=4
//
//   Handshake: every pulse input is sampled for exactly one posedge; every
//   output except mag_on is registered and follows its cause by one cycle.
module cook_sequencer #(
  parameter int MAX_DIGITS  = 4,
  parameter int DUTY_WINDOW = 10,
  parameter int BEEP_TICKS  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       power_key,
  input  logic       start_pulse,
  input  logic       stop_pulse,
  input  logic       clear_pulse,
  input  logic       door_closed,
  input  logic       tick_1hz,
  input  logic       timer_zero,
  output logic [3:0] digit_data,
  output logic       digit_load,
  output logic       counter_clear,
  output logic       count_enable,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state_o
);

  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [2:0]    MAX_CNT    = 3'(MAX_DIGITS);
  localparam logic [3:0]    PHASE_LAST = 4'(DUTY_WINDOW - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TICKS - 1);
  localparam logic [3:0]    FULL_POWER = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_COOK   = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    power_q, power_d;
  logic [3:0]    phase_q, phase_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic          armed_q, armed_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;

  logic [3:0]    digit_data_q, digit_data_d;
  logic          digit_load_q, digit_load_d;
  logic          counter_clear_q, counter_clear_d;
  logic          count_enable_q, count_enable_d;
  logic          mag_q, mag_d;
  logic          beep_q, beep_d;

  logic          digit_ok;
  logic [3:0]    digit_power;

  assign digit_ok    = key_valid && (key_code < 4'd10);
  // Power digit 0 means full power (10).
  assign digit_power = (key_code == 4'd0) ? FULL_POWER : key_code;

  always_comb begin
    state_d         = state_q;
    power_d         = power_q;
    phase_d         = phase_q;
    digit_cnt_d     = digit_cnt_q;
    armed_d         = armed_q;
    beep_cnt_d      = beep_cnt_q;
    digit_data_d    = digit_data_q;
    digit_load_d    = 1'b0;
    counter_clear_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_pulse) begin
          counter_clear_d = 1'b1;
          power_d         = FULL_POWER;
          armed_d         = 1'b0;
        end else begin
          if (digit_ok) begin
            if (armed_q) begin
              power_d = digit_power;
              armed_d = 1'b0;
            end else begin
              digit_load_d = 1'b1;
              digit_data_d = key_code;
              digit_cnt_d  = 3'd1;
              state_d      = S_ENTRY;
            end
          end
          // Arms for the following digit, not one arriving in the same cycle.
          if (power_key) armed_d = 1'b1;
        end
      end

      S_ENTRY: begin
        if (clear_pulse || stop_pulse) begin
          counter_clear_d = 1'b1;
          digit_cnt_d     = 3'd0;
          power_d         = FULL_POWER;
          armed_d         = 1'b0;
          state_d         = S_IDLE;
        end else if (start_pulse && door_closed && !timer_zero) begin
          phase_d = 4'd0;
          state_d = S_COOK;
        end else begin
          if (digit_ok) begin
            if (armed_q) begin
              power_d = digit_power;
              armed_d = 1'b0;
            end else if (digit_cnt_q < MAX_CNT) begin
              digit_load_d = 1'b1;
              digit_data_d = key_code;
              digit_cnt_d  = digit_cnt_q + 3'd1;
            end
          end
          if (power_key) armed_d = 1'b1;
        end
      end

      S_COOK: begin
        if (clear_pulse) begin
          counter_clear_d = 1'b1;
          digit_cnt_d     = 3'd0;
          power_d         = FULL_POWER;
          armed_d         = 1'b0;
          state_d         = S_IDLE;
        end else if (stop_pulse || !door_closed) begin
          // Phase is held so the duty cycle resumes where it left off.
          state_d = S_PAUSED;
        end else if (timer_zero) begin
          beep_cnt_d = '0;
          state_d    = S_DONE;
        end else if (tick_1hz) begin
          phase_d = (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 4'd1;
        end
      end

      S_PAUSED: begin
        if (clear_pulse || stop_pulse) begin
          counter_clear_d = 1'b1;
          digit_cnt_d     = 3'd0;
          power_d         = FULL_POWER;
          armed_d         = 1'b0;
          state_d         = S_IDLE;
        end else if (start_pulse && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        // Any button or digit only silences the beep; it is not acted on further.
        if (start_pulse || stop_pulse || clear_pulse || digit_ok) begin
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end else if (tick_1hz) begin
          if (beep_cnt_q == BEEP_LAST) begin
            digit_cnt_d = 3'd0;
            state_d     = S_IDLE;
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    count_enable_d = (state_d == S_COOK);
    mag_d          = (state_d == S_COOK) && (phase_d < power_d);
    beep_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      power_q         <= FULL_POWER;
      phase_q         <= 4'd0;
      digit_cnt_q     <= 3'd0;
      armed_q         <= 1'b0;
      beep_cnt_q      <= '0;
      digit_data_q    <= 4'd0;
      digit_load_q    <= 1'b0;
      counter_clear_q <= 1'b0;
      count_enable_q  <= 1'b0;
      mag_q           <= 1'b0;
      beep_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      power_q         <= power_d;
      phase_q         <= phase_d;
      digit_cnt_q     <= digit_cnt_d;
      armed_q         <= armed_d;
      beep_cnt_q      <= beep_cnt_d;
      digit_data_q    <= digit_data_d;
      digit_load_q    <= digit_load_d;
      counter_clear_q <= counter_clear_d;
      count_enable_q  <= count_enable_d;
      mag_q           <= mag_d;
      beep_q          <= beep_d;
    end
  end

  assign digit_data    = digit_data_q;
  assign digit_load    = digit_load_q;
  assign counter_clear = counter_clear_q;
  assign count_enable  = count_enable_q;
  // Door gating is combinational so the magnetron stops the instant the door opens.
  assign mag_on        = mag_q & door_closed;
  assign beep          = beep_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
module tb_cook_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid, power_key, start_pulse, stop_pulse, clear_pulse;
  logic       door_closed, tick_1hz, timer_zero;
  logic [3:0] key_code;
  logic [3:0] digit_data;
  logic       digit_load, counter_clear, count_enable, mag_on, beep;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cook_sequencer dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .power_key(power_key), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .clear_pulse(clear_pulse), .door_closed(door_closed), .tick_1hz(tick_1hz),
    .timer_zero(timer_zero), .digit_data(digit_data), .digit_load(digit_load),
    .counter_clear(counter_clear), .count_enable(count_enable), .mag_on(mag_on),
    .beep(beep), .state_o(state_o)
  );

  // Inputs are set just after a negedge; cycle() lets one posedge pass, then
  // drops the pulse inputs at the following negedge where outputs are checked.
  task automatic cycle();
    @(negedge clock);
    key_valid = 0; power_key = 0; start_pulse = 0;
    stop_pulse = 0; clear_pulse = 0; tick_1hz = 0;
  endtask

  task automatic key(input logic [3:0] code);
    key_valid = 1; key_code = code; cycle();
  endtask

  task automatic tick();
    tick_1hz = 1; cycle();
  endtask

  task automatic test_reset();
    reset = 1; key_valid = 0; key_code = 0; power_key = 0; start_pulse = 0;
    stop_pulse = 0; clear_pulse = 0; door_closed = 1; tick_1hz = 0; timer_zero = 0;
    repeat (3) @(negedge clock);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if ({digit_load, counter_clear, count_enable, mag_on, beep} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {digit_load, counter_clear, count_enable, mag_on, beep}); end
    checks++; if (digit_data !== 4'd0) begin errors++; $display("FAIL reset_digit_data: got %0d expected 0", digit_data); end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_entry_cook();
    logic [3:0] digits [3];
    digits[0] = 1; digits[1] = 3; digits[2] = 0;
    for (int i = 0; i < 3; i++) begin
      key(digits[i]);
      checks++; if (digit_load !== 1'b1 || digit_data !== digits[i]) begin
        errors++; $display("FAIL entry_load%0d: got load=%0d data=%0d expected load=1 data=%0d", i, digit_load, digit_data, digits[i]); end
      checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL entry_state%0d: got %0d expected 1", i, state_o); end
    end
    cycle();
    checks++; if (digit_load !== 1'b0) begin errors++; $display("FAIL entry_load_pulse: got %0d expected 0", digit_load); end
    start_pulse = 1; cycle();
    checks++; if (state_o !== 3'd2 || count_enable !== 1'b1 || mag_on !== 1'b1) begin
      errors++; $display("FAIL start_cook: got state=%0d ce=%0d mag=%0d expected 2 1 1", state_o, count_enable, mag_on); end
    stop_pulse = 1; cycle();
    checks++; if (state_o !== 3'd3 || count_enable !== 1'b0 || mag_on !== 1'b0) begin
      errors++; $display("FAIL stop_pause: got state=%0d ce=%0d mag=%0d expected 3 0 0", state_o, count_enable, mag_on); end
    stop_pulse = 1; cycle();
    checks++; if (state_o !== 3'd0 || counter_clear !== 1'b1) begin
      errors++; $display("FAIL stop_idle: got state=%0d clr=%0d expected 0 1", state_o, counter_clear); end
  endtask

  task automatic test_power();
    power_key = 1; cycle();
    key(5);
    checks++; if (digit_load !== 1'b0 || state_o !== 3'd0) begin
      errors++; $display("FAIL power_digit: got load=%0d state=%0d expected 0 0", digit_load, state_o); end
    key(2);
    checks++; if (digit_load !== 1'b1 || digit_data !== 4'd2 || state_o !== 3'd1) begin
      errors++; $display("FAIL power_time_digit: got load=%0d data=%0d state=%0d expected 1 2 1", digit_load, digit_data, state_o); end
    start_pulse = 1; cycle();
    checks++; if (mag_on !== 1'b1 || state_o !== 3'd2) begin
      errors++; $display("FAIL power_start: got mag=%0d state=%0d expected 1 2", mag_on, state_o); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (mag_on !== ((k % 10) < 5)) begin
        errors++; $display("FAIL power_duty_tick%0d: got %0d expected %0d", k, mag_on, ((k % 10) < 5)); end
    end
  endtask

  task automatic test_door();
    // Phase is now 2 with power 5.
    door_closed = 0; #1;
    checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL door_mag_comb: got %0d expected 0", mag_on); end
    cycle();
    checks++; if (state_o !== 3'd3 || count_enable !== 1'b0) begin
      errors++; $display("FAIL door_pause: got state=%0d ce=%0d expected 3 0", state_o, count_enable); end
    tick(); tick();
    start_pulse = 1; cycle();
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL door_open_start: got %0d expected 3", state_o); end
    door_closed = 1; start_pulse = 1; cycle();
    checks++; if (state_o !== 3'd2 || mag_on !== 1'b1) begin
      errors++; $display("FAIL door_resume: got state=%0d mag=%0d expected 2 1", state_o, mag_on); end
    tick(); tick();
    checks++; if (mag_on !== 1'b1) begin errors++; $display("FAIL resume_phase4: got %0d expected 1", mag_on); end
    tick();
    checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL resume_phase5: got %0d expected 0", mag_on); end
  endtask

  task automatic test_done();
    timer_zero = 1; cycle();
    checks++; if (state_o !== 3'd4 || beep !== 1'b1 || mag_on !== 1'b0 || count_enable !== 1'b0) begin
      errors++; $display("FAIL done_enter: got state=%0d beep=%0d mag=%0d ce=%0d expected 4 1 0 0", state_o, beep, mag_on, count_enable); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++; if (state_o !== 3'd4 || beep !== 1'b1) begin
        errors++; $display("FAIL done_beep_tick%0d: got state=%0d beep=%0d expected 4 1", k, state_o, beep); end
    end
    tick();
    checks++; if (state_o !== 3'd0 || beep !== 1'b0) begin
      errors++; $display("FAIL done_expire: got state=%0d beep=%0d expected 0 0", state_o, beep); end
    timer_zero = 0; cycle();
  endtask

  task automatic test_done_stop();
    key(7);
    start_pulse = 1; cycle();
    timer_zero = 1; cycle();
    tick();
    checks++; if (beep !== 1'b1 || state_o !== 3'd4) begin
      errors++; $display("FAIL done2_beep: got beep=%0d state=%0d expected 1 4", beep, state_o); end
    stop_pulse = 1; cycle();
    checks++; if (state_o !== 3'd0 || beep !== 1'b0 || counter_clear !== 1'b0) begin
      errors++; $display("FAIL done_stop: got state=%0d beep=%0d clr=%0d expected 0 0 0", state_o, beep, counter_clear); end
    timer_zero = 0; cycle();
  endtask

  task automatic test_max_digits();
    int loads;
    loads = 0;
    for (int i = 1; i <= 5; i++) begin
      key(4'(i));
      if (digit_load === 1'b1) loads++;
    end
    checks++; if (loads !== 4) begin errors++; $display("FAIL max_digits: got %0d loads expected 4", loads); end
    key(4'd12);
    checks++; if (digit_load !== 1'b0) begin errors++; $display("FAIL bad_code: got load=%0d expected 0", digit_load); end
    door_closed = 0; start_pulse = 1; cycle();
    checks++; if (state_o !== 3'd1 || count_enable !== 1'b0) begin
      errors++; $display("FAIL start_door_open: got state=%0d ce=%0d expected 1 0", state_o, count_enable); end
    door_closed = 1; cycle();
  endtask

  task automatic test_clear_start();
    int mag_seen;
    mag_seen = 0;
    clear_pulse = 1; start_pulse = 1; cycle();
    checks++; if (counter_clear !== 1'b1 || state_o !== 3'd0) begin
      errors++; $display("FAIL clear_start: got clr=%0d state=%0d expected 1 0", counter_clear, state_o); end
    for (int i = 0; i < 4; i++) begin
      if (mag_on === 1'b1) mag_seen++;
      cycle();
    end
    checks++; if (mag_seen !== 0) begin errors++; $display("FAIL clear_start_mag: got %0d cycles on expected 0", mag_seen); end
    clear_pulse = 1; cycle();
    checks++; if (counter_clear !== 1'b1 || state_o !== 3'd0) begin
      errors++; $display("FAIL idle_clear: got clr=%0d state=%0d expected 1 0", counter_clear, state_o); end
    cycle();
    checks++; if (counter_clear !== 1'b0) begin errors++; $display("FAIL clear_pulse_width: got %0d expected 0", counter_clear); end
  endtask

  task automatic test_reset_mid_cook();
    key(9);
    start_pulse = 1; cycle();
    #2 reset = 1; #1;
    checks++; if (mag_on !== 1'b0 || count_enable !== 1'b0 || state_o !== 3'd0 || counter_clear !== 1'b0) begin
      errors++; $display("FAIL reset_mid_cook: got mag=%0d ce=%0d state=%0d clr=%0d expected 0 0 0 0", mag_on, count_enable, state_o, counter_clear); end
    @(negedge clock); reset = 0; cycle();
  endtask

  initial begin
    test_reset();
    test_entry_cook();
    test_power();
    test_door();
    test_done();
    test_done_stop();
    test_max_digits();
    test_clear_start();
    test_reset_mid_cook();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
